uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//  Receive-side byte buffer directly downstream of the UART receiver.
//  Captures each completed frame (rx_done strobe + rx_data byte) into a DEPTH-entry
//  first-word-fall-through FIFO and presents bytes on a valid/ready stream to the host logic.
//  Flags overrun when a frame completes while the buffer is full, so dropped bytes are never silent.
// PARAMETERS
//  DEPTH      16  number of byte entries; power of 2, >= 2
//  AW         4   pointer width, = log2(DEPTH)
//  AFULL_LVL  12  almost_full asserts when level >= AFULL_LVL; 1..DEPTH
// PORTS
//  clk          in   1     system clock (same domain as the receiver)
//  rst          in   1     asynchronous, active-high reset
//  rx_done      in   1     frame-complete strobe from the receiver
//  rx_data      in   8     received byte; stable while rx_done is high
//  flush        in   1     synchronous clear of FIFO contents
//  overrun_clr  in   1     clears the sticky overrun flag
//  m_valid      out  1     head byte available (= !empty)
//  m_ready      in   1     consumer accepts the head byte
//  m_data       out  8     head byte (mem[rd_ptr]); meaningful only when m_valid=1
//  level        out  AW+1  bytes stored, 0..DEPTH
//  empty        out  1     level == 0
//  full         out  1     level == DEPTH
//  almost_full  out  1     level >= AFULL_LVL
//  overrun      out  1     sticky; a byte was dropped
// BEHAVIOUR
//  Reset:
//   - rst=1 clears pointers, level, overrun and the rx_done delay register.
//   - Outputs during reset: m_valid=0, empty=1, full=0, almost_full=0, level=0, overrun=0.
//   - Memory contents are not reset.
//   - Reset mid-frame or mid-burst discards all stored bytes.
//  Capture:
//   - done_d is a register of rx_done.
//   - push_req = rx_done & ~done_d, i.e. one push per rising edge of rx_done.
//   - A strobe held high for several cycles writes exactly once.
//  Pop:
//   - pop = m_valid & m_ready.
//   - rd_ptr advances on the clock edge where pop=1.
//   - m_data shows the next entry in the following cycle.
//  Push:
//   - push = push_req & (!full | pop).
//   - rx_data is written to mem[wr_ptr] and wr_ptr advances.
//   - A write while full is accepted when a pop occurs in the same cycle.
//  Latency:
//   - A byte pushed at edge N is visible on m_valid/m_data after edge N (first-word fall-through).
//   - Zero extra cycles when the FIFO is empty.
//  Level update per edge:
//   - push & !pop: +1
//   - pop & !push: -1
//   - push & pop: unchanged
//  Pointers:
//   - AW bits wide; wrap from DEPTH-1 to 0 naturally.
//   - full/empty are derived from level, not from pointer compare.
//  Overrun:
//   - push_req & full & !pop drops the byte: no pointer or level change, and overrun is set.
//   - overrun stays set until overrun_clr=1.
//   - If overrun_clr and a new drop occur in the same cycle, set wins.
//  Flush:
//   - On the edge with flush=1, pointers and level go to 0.
//   - Any push or pop in that same cycle is discarded.
//   - overrun is unaffected.
//   - done_d still updates, so an rx_done held across the flush does not re-push afterwards.
//  Handshake:
//   - m_valid does not depend combinationally on m_ready.
//   - The consumer may hold m_ready=1 continuously.
//   - m_data is stable while m_valid=1 and m_ready=0.
// TESTING
//  1. Push 0xA5 then 0x3C via single-cycle rx_done, m_ready=0
//     -> level=2, m_data=0xA5; then m_ready=1 for two cycles -> 0xA5, 0x3C popped, empty=1.
//  2. rx_done held high for 5 cycles with rx_data=0x55 -> exactly one push, level=1.
//  3. Push 16 bytes 0x00..0x0F -> almost_full rises at level 12, full=1 at 16;
//     17th push 0xFF -> dropped, overrun=1, level=16; drain -> 0x00..0x0F in order.
//  4. Full FIFO, 17th push coincident with pop -> push accepted, level stays 16,
//     overrun=0, last byte read out is the new byte.
//  5. level=5, flush=1 with simultaneous push and pop -> level=0, empty=1, no byte enqueued;
//     overrun_clr=1 with a drop in the same cycle -> overrun stays 1.
//  6. Assert rst with level=7 and m_valid=1 -> m_valid=0, level=0, overrun=0 immediately (async);
//     after release, next push is read out first.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_if
//   Groups the receiver-facing capture signals and the host-facing
//   valid/ready byte stream of the UART receive buffer.
//
//   Signals
//     rx_done  frame-complete strobe from the UART receiver
//     rx_data  received byte, stable while rx_done is high
//     m_valid  head byte available
//     m_ready  consumer accepts the head byte
//     m_data   head byte
//
//   Modports
//     master   the buffer: consumes rx_done/rx_data, drives the stream
//     slave    the surroundings: receiver strobes plus the host consumer
// ---------------------------------------------------------------------------
interface uart_rx_fifo_if;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;

  modport master (
    input  rx_done,
    input  rx_data,
    input  m_ready,
    output m_valid,
    output m_data
  );

  modport slave (
    output rx_done,
    output rx_data,
    output m_ready,
    input  m_valid,
    input  m_data
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//   Receive-side byte buffer sitting directly behind the UART receiver.
//   Every completed frame (rising edge of rx_done) is captured into a
//   DEPTH-entry first-word-fall-through FIFO; bytes leave on a valid/ready
//   stream. A frame that completes while the buffer is full and nothing is
//   leaving is dropped and latches the sticky overrun flag.
//
//   Parameters
//     DEPTH      number of byte entries, power of two, >= 2
//     AW         pointer width, log2(DEPTH)
//     AFULL_LVL  almost_full threshold, 1..DEPTH
//
//   Ports
//     clk          system clock (same domain as the receiver)
//     rst          asynchronous, active-high reset
//     bus          uart_rx_fifo_if.master: rx_done/rx_data in,
//                  m_valid/m_data out, m_ready in
//     flush        synchronous clear of the buffer contents
//     overrun_clr  clears the sticky overrun flag
//     level        bytes stored, 0..DEPTH
//     empty        level == 0
//     full         level == DEPTH
//     almost_full  level >= AFULL_LVL
//     overrun      sticky, a byte was dropped
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AW        = 4,
  parameter int unsigned AFULL_LVL = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_rx_fifo_if.master        bus,
  input  logic                  flush,
  input  logic                  overrun_clr,
  output logic [AW:0]           level,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overrun
);

  localparam logic [AW:0] DepthLvl = DEPTH[AW:0];
  localparam logic [AW:0] AfullLvl = AFULL_LVL[AW:0];

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          overrun_q, overrun_d;
  logic          done_q;

  // -------------------------------------------------------------------------
  // Handshake decode
  // -------------------------------------------------------------------------
  logic push_req;
  logic pop;
  logic push;
  logic drop;
  logic is_empty;
  logic is_full;

  assign is_empty = (level_q == '0);
  assign is_full  = (level_q == DepthLvl);

  // One push per rising edge of rx_done, however long the strobe is held.
  assign push_req = bus.rx_done & ~done_q;

  // m_valid comes straight from the level register, so pop never loops back
  // combinationally into m_valid.
  assign pop  = ~is_empty & bus.m_ready;

  // A pop in the same cycle frees the slot the incoming byte needs.
  assign push = push_req & (~is_full | pop);
  assign drop = push_req & is_full & ~pop;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (flush) begin
      // Flush wins over any push or pop in the same cycle.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  // A fresh drop beats a simultaneous clear so no loss goes unreported.
  // Flush deliberately leaves the flag alone.
  always_comb begin
    overrun_d = overrun_q;
    if (drop) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      overrun_q <= overrun_d;
      // Tracks rx_done even during flush so a held strobe cannot re-push.
      done_q    <= bus.rx_done;
    end
  end

  // Storage array carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr_q] <= bus.rx_data;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.m_valid = ~is_empty;
  assign bus.m_data  = mem[rd_ptr_q];

  assign level       = level_q;
  assign empty       = is_empty;
  assign full        = is_full;
  assign almost_full = (level_q >= AfullLvl);
  assign overrun     = overrun_q;

endmodule
